// File: rtl/mac_tile_pkg.sv
// ---------------------------------------------------------------------------
// mac_tile_pkg
//   Shared definitions for the flexible MAC tile: controller states,
//   bit positions inside the 3-bit instruction word and the dataflow mode
//   encodings. Optional build macro used by the tile: MAC_TILE_FLEX_SAT_EN.
// ---------------------------------------------------------------------------
package mac_tile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_EXEC       = 2'd1,
        ST_DRAIN_SELF = 2'd2,
        ST_DRAIN_PASS = 2'd3
    } state_t;

    localparam int INST_W     = 3;
    localparam int INST_LOAD  = 0;
    localparam int INST_EXEC  = 1;
    localparam int INST_DRAIN = 2;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

endpackage : mac_tile_pkg

// File: rtl/mac_tile_flex_mac.sv
// ---------------------------------------------------------------------------
// mac_tile_flex_mac
//   Combinational multiply-accumulate y = a*b + c.
//   Ports:
//     a  in  BW         unsigned activation
//     b  in  BW         signed weight
//     c  in  PSUM_BW    signed addend (psum from north or accumulator)
//     y  out PSUM_BW+1  signed full-precision sum; the extra MSB lets the
//                       caller detect overflow before wrapping or clamping
// ---------------------------------------------------------------------------
module mac_tile_flex_mac
    import mac_tile_pkg::*;
#(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16
) (
    input  logic        [BW-1:0]    a,
    input  logic signed [BW-1:0]    b,
    input  logic signed [PSUM_BW-1:0] c,
    output logic signed [PSUM_BW:0] y
);

    logic signed [BW:0]     a_s;
    logic signed [2*BW:0]   a_x;
    logic signed [2*BW:0]   b_x;
    logic signed [2*BW:0]   prod;

    always_comb begin
        // Zero-extend the unsigned activation so the multiply stays signed.
        a_s  = $signed({1'b0, a});
        a_x  = (2*BW+1)'(a_s);
        b_x  = (2*BW+1)'(b);
        prod = a_x * b_x;
        y    = (PSUM_BW+1)'(prod) + (PSUM_BW+1)'(c);
    end

endmodule : mac_tile_flex_mac

// File: rtl/mac_tile_flex.sv
// ---------------------------------------------------------------------------
// mac_tile_flex
//   Systolic-array processing element supporting weight-stationary (WS) and
//   output-stationary (OS) dataflows, chosen at run time while idle.
//   Build option: define MAC_TILE_FLEX_SAT_EN to saturate the WS psum add and
//   the OS accumulation; otherwise both wrap modulo 2^PSUM_BW.
//   PSUM_BW must be at least 2*BW+1.
//   Ports:
//     clk      in   clock, all state on rising edge
//     reset    in   synchronous, active-high
//     mode     in   0 = WS, 1 = OS; taken only when idle with no instruction
//     in_w     in   BW       activation (WS load: weight) from west
//     inst_w   in   3        [0] load, [1] execute, [2] drain
//     in_n     in   PSUM_BW  WS psum / OS weight (low BW bits) / drain data
//     out_e    out  BW       registered activation to east
//     inst_e   out  3        registered instruction to east
//     out_s    out  PSUM_BW  registered psum / weight / drain data to south
//     valid_s  out  1        out_s carries a result
// ---------------------------------------------------------------------------
module mac_tile_flex
    import mac_tile_pkg::*;
#(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [BW-1:0]      in_w,
    input  logic [INST_W-1:0]  inst_w,
    input  logic [PSUM_BW-1:0] in_n,
    output logic [BW-1:0]      out_e,
    output logic [INST_W-1:0]  inst_e,
    output logic [PSUM_BW-1:0] out_s,
    output logic               valid_s
);

    // Fit the full-precision MAC result back into PSUM_BW bits.
    function automatic logic signed [PSUM_BW-1:0] fit_psum(input logic signed [PSUM_BW:0] x);
`ifdef MAC_TILE_FLEX_SAT_EN
        // The two top bits disagree only when the sum left the PSUM_BW range.
        if (x[PSUM_BW] != x[PSUM_BW-1]) begin
            if (x[PSUM_BW]) fit_psum = {1'b1, {(PSUM_BW-1){1'b0}}};
            else            fit_psum = {1'b0, {(PSUM_BW-1){1'b1}}};
        end else begin
            fit_psum = x[PSUM_BW-1:0];
        end
`else
        fit_psum = x[PSUM_BW-1:0];
`endif
    endfunction

    state_t                    state_q, state_d;
    logic                      mode_q, mode_d;
    logic                      load_ready_q, load_ready_d;
    logic signed [BW-1:0]      weight_q, weight_d;
    logic signed [PSUM_BW-1:0] acc_q, acc_d;
    logic [BW-1:0]             a_q, a_d;
    logic [INST_W-1:0]         inst_e_q, inst_e_d;
    logic [PSUM_BW-1:0]        out_s_q, out_s_d;
    logic                      valid_s_q, valid_s_d;

    logic                      drain_act, load_act, exec_act;
    logic signed [BW-1:0]      mac_b;
    logic signed [PSUM_BW-1:0] mac_c;
    logic signed [PSUM_BW:0]   mac_sum;

    // Local priority: drain > load > execute. Drain only means something in
    // OS mode; in WS it is forwarded east but otherwise ignored.
    always_comb begin
        drain_act = inst_w[INST_DRAIN] && (mode_q == MODE_OS);
        load_act  = inst_w[INST_LOAD] && !drain_act;
        exec_act  = inst_w[INST_EXEC] && !inst_w[INST_LOAD] && !drain_act;
    end

    // One shared MAC: WS uses the stored weight plus the north psum, OS uses
    // the streamed weight from north plus the local accumulator.
    always_comb begin
        if (mode_q == MODE_OS) begin
            mac_b = $signed(in_n[BW-1:0]);
            mac_c = acc_q;
        end else begin
            mac_b = weight_q;
            mac_c = $signed(in_n);
        end
    end

    mac_tile_flex_mac #(
        .BW      (BW),
        .PSUM_BW (PSUM_BW)
    ) u_mac (
        .a (in_w),
        .b (mac_b),
        .c (mac_c),
        .y (mac_sum)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        load_ready_d = load_ready_q;
        weight_d     = weight_q;
        acc_d        = acc_q;
        a_d          = a_q;
        inst_e_d     = inst_w;
        out_s_d      = out_s_q;
        valid_s_d    = 1'b0;

        if (state_q == ST_IDLE && inst_w == '0) begin
            mode_d = mode;
        end

        if (load_act || exec_act) begin
            a_d = in_w;
        end

        if (drain_act) begin
            // First drain cycle emits this tile's result, later ones pass the
            // column's upstream results through.
            if (state_q == ST_DRAIN_SELF || state_q == ST_DRAIN_PASS) begin
                out_s_d = in_n;
                state_d = ST_DRAIN_PASS;
            end else begin
                out_s_d = acc_q;
                acc_d   = '0;
                state_d = ST_DRAIN_SELF;
            end
            valid_s_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE:       if (exec_act)  state_d = ST_EXEC;
                ST_EXEC:       if (!exec_act) state_d = ST_IDLE;
                ST_DRAIN_SELF: state_d = ST_DRAIN_PASS;
                ST_DRAIN_PASS: state_d = ST_IDLE;
                default:       state_d = ST_IDLE;
            endcase

            if (load_act) begin
                if (mode_q == MODE_OS) begin
                    acc_d = '0;
                end else if (load_ready_q) begin
                    // This tile keeps the first weight; later ones travel east.
                    weight_d           = $signed(in_w);
                    load_ready_d       = 1'b0;
                    inst_e_d[INST_LOAD] = 1'b0;
                end
            end else if (exec_act) begin
                if (mode_q == MODE_OS) begin
                    out_s_d = {{(PSUM_BW-BW){1'b0}}, in_n[BW-1:0]};
                    acc_d   = fit_psum(mac_sum);
                end else begin
                    out_s_d   = fit_psum(mac_sum);
                    valid_s_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_WS;
            load_ready_q <= 1'b1;
            weight_q     <= '0;
            acc_q        <= '0;
            a_q          <= '0;
            inst_e_q     <= '0;
            out_s_q      <= '0;
            valid_s_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            load_ready_q <= load_ready_d;
            weight_q     <= weight_d;
            acc_q        <= acc_d;
            a_q          <= a_d;
            inst_e_q     <= inst_e_d;
            out_s_q      <= out_s_d;
            valid_s_q    <= valid_s_d;
        end
    end

    assign out_e   = a_q;
    assign inst_e  = inst_e_q;
    assign out_s   = out_s_q;
    assign valid_s = valid_s_q;

endmodule : mac_tile_flex

// File: tb/tb_mac_tile_flex.sv
module tb_mac_tile_flex;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;

    typedef struct packed {
        logic [BW-1:0]      oe;
        logic [2:0]         ie;
        logic [PSUM_BW-1:0] os;
        logic               vs;
        logic               c_oe;
        logic               c_os;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               mode = 1'b0;
    logic [BW-1:0]      in_w = '0;
    logic [2:0]         inst_w = '0;
    logic [PSUM_BW-1:0] in_n = '0;
    logic [BW-1:0]      out_e;
    logic [2:0]         inst_e;
    logic [PSUM_BW-1:0] out_s;
    logic               valid_s;

    int checks = 0;
    int failures = 0;

    exp_t  sb_q[$];
    string tag_q[$];

    logic [PSUM_BW-1:0] ovf_exp;

    mac_tile_flex #(.BW(BW), .PSUM_BW(PSUM_BW)) dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .in_w    (in_w),
        .inst_w  (inst_w),
        .in_n    (in_n),
        .out_e   (out_e),
        .inst_e  (inst_e),
        .out_s   (out_s),
        .valid_s (valid_s)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue what the registered outputs must show
    // after the next rising edge, then pop and compare once they settle.
    task automatic step(input string tag, input logic rst, input logic md,
                        input logic [2:0] inst, input logic [BW-1:0] w,
                        input logic [PSUM_BW-1:0] n,
                        input logic c_oe, input logic [BW-1:0] e_oe,
                        input logic [2:0] e_ie,
                        input logic c_os, input logic [PSUM_BW-1:0] e_os,
                        input logic e_vs);
        exp_t  e;
        string t;
        reset  = rst;
        mode   = md;
        inst_w = inst;
        in_w   = w;
        in_n   = n;
        e.oe = e_oe; e.ie = e_ie; e.os = e_os; e.vs = e_vs;
        e.c_oe = c_oe; e.c_os = c_os;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (inst_e === e.ie) else begin
            failures++;
            $error("FAIL %s.inst_e observed=%0h expected=%0h", t, inst_e, e.ie);
        end
        checks++;
        assert (valid_s === e.vs) else begin
            failures++;
            $error("FAIL %s.valid_s observed=%0h expected=%0h", t, valid_s, e.vs);
        end
        if (e.c_oe) begin
            checks++;
            assert (out_e === e.oe) else begin
                failures++;
                $error("FAIL %s.out_e observed=%0h expected=%0h", t, out_e, e.oe);
            end
        end
        if (e.c_os) begin
            checks++;
            assert (out_s === e.os) else begin
                failures++;
                $error("FAIL %s.out_s observed=%0h expected=%0h", t, out_s, e.os);
            end
        end
    endtask

    initial begin
`ifdef MAC_TILE_FLEX_SAT_EN
        ovf_exp = 16'h7FFF;   // 313*105 = 32865 clamps to 32767
`else
        ovf_exp = 16'h8061;   // 32865 - 65536 = -32671
`endif
        //    tag            rst md inst    in_w  in_n      c_oe oe   ie      c_os os         vs
        step("reset",        1, 0, 3'b000, 4'd0, 16'd0,    1, 4'd0, 3'b000, 1, 16'd0,     0);
        step("post_reset",   0, 0, 3'b000, 4'd0, 16'd0,    1, 4'd0, 3'b000, 1, 16'd0,     0);

        // WS: first load captured and not forwarded, later loads forwarded
        step("ws_load1",     0, 0, 3'b001, 4'd3, 16'd0,    1, 4'd3, 3'b000, 1, 16'd0,     0);
        step("ws_load2",     0, 0, 3'b001, 4'd7, 16'd0,    1, 4'd7, 3'b001, 1, 16'd0,     0);
        step("ws_load3",     0, 0, 3'b001, 4'd9, 16'd0,    1, 4'd9, 3'b001, 1, 16'd0,     0);
        step("ws_exec1",     0, 0, 3'b010, 4'd5, 16'd10,   1, 4'd5, 3'b010, 1, 16'd25,    1);
        step("ws_exec_neg",  0, 0, 3'b010, 4'd15, 16'hFF9C, 1, 4'd15, 3'b010, 1, 16'hFFC9, 1);
        step("ws_idle",      0, 0, 3'b000, 4'd1, 16'd2,    1, 4'd15, 3'b000, 1, 16'hFFC9, 0);
        step("ws_drain_ign", 0, 0, 3'b100, 4'd1, 16'd2,    1, 4'd15, 3'b100, 1, 16'hFFC9, 0);
        step("to_os",        0, 1, 3'b000, 4'd0, 16'd0,    1, 4'd15, 3'b000, 1, 16'hFFC9, 0);

        // OS: accumulate (2,-1),(3,4),(1,7) = 17, then drain self and pass
        step("os_load",      0, 1, 3'b001, 4'd0, 16'd0,    1, 4'd0, 3'b001, 1, 16'hFFC9, 0);
        step("os_exec1",     0, 1, 3'b010, 4'd2, 16'h000F, 1, 4'd2, 3'b010, 1, 16'h000F, 0);
        step("os_exec2",     0, 1, 3'b010, 4'd3, 16'd4,    1, 4'd3, 3'b010, 1, 16'd4,     0);
        step("os_exec3",     0, 1, 3'b010, 4'd1, 16'd7,    1, 4'd1, 3'b010, 1, 16'd7,     0);
        step("os_drain_self",0, 1, 3'b100, 4'd0, 16'd99,   1, 4'd1, 3'b100, 1, 16'd17,    1);
        step("os_drain_pass",0, 1, 3'b100, 4'd0, 16'd99,   1, 4'd1, 3'b100, 1, 16'd99,    1);
        step("os_idle1",     0, 1, 3'b000, 4'd0, 16'd0,    0, 4'd0, 3'b000, 1, 16'd99,    0);
        step("os_acc_zero",  0, 1, 3'b100, 4'd0, 16'd5,    0, 4'd0, 3'b100, 1, 16'd0,     1);
        step("os_idle2",     0, 1, 3'b000, 4'd0, 16'd0,    0, 4'd0, 3'b000, 1, 16'd0,     0);
        step("os_idle3",     0, 1, 3'b000, 4'd0, 16'd0,    0, 4'd0, 3'b000, 1, 16'd0,     0);

        // OS: drain together with execute, acc=12, product must be dropped
        step("dx_load",      0, 1, 3'b001, 4'd0, 16'd0,    1, 4'd0, 3'b001, 0, 16'd0,     0);
        step("dx_exec",      0, 1, 3'b010, 4'd3, 16'd4,    1, 4'd3, 3'b010, 1, 16'd4,     0);
        step("dx_both",      0, 1, 3'b110, 4'd5, 16'd2,    1, 4'd3, 3'b110, 1, 16'd12,    1);
        step("dx_pass",      0, 1, 3'b100, 4'd0, 16'h1234, 1, 4'd3, 3'b100, 1, 16'h1234,  1);
        step("dx_idle",      0, 1, 3'b000, 4'd0, 16'd0,    0, 4'd0, 3'b000, 0, 16'd0,     0);
        step("dx_acc_zero",  0, 1, 3'b100, 4'd0, 16'd0,    0, 4'd0, 3'b100, 1, 16'd0,     1);
        step("dx_idle2",     0, 1, 3'b000, 4'd0, 16'd0,    0, 4'd0, 3'b000, 0, 16'd0,     0);
        step("dx_idle3",     0, 1, 3'b000, 4'd0, 16'd0,    0, 4'd0, 3'b000, 0, 16'd0,     0);

        // OS overflow: 313 * (15*7)
        step("ovf_load",     0, 1, 3'b001, 4'd0, 16'd0,    1, 4'd0, 3'b001, 0, 16'd0,     0);
        for (int i = 0; i < 313; i++) begin
            step("ovf_exec", 0, 1, 3'b010, 4'd15, 16'd7,   1, 4'd15, 3'b010, 1, 16'd7,    0);
        end
        step("ovf_drain",    0, 1, 3'b100, 4'd0, 16'd0,    1, 4'd15, 3'b100, 1, ovf_exp,  1);
        step("ovf_idle1",    0, 1, 3'b000, 4'd0, 16'd0,    0, 4'd0, 3'b000, 0, 16'd0,     0);
        step("ovf_idle2",    0, 1, 3'b000, 4'd0, 16'd0,    0, 4'd0, 3'b000, 0, 16'd0,     0);

        // Mode change while executing is ignored: tile stays OS
        step("mx_exec1",     0, 0, 3'b010, 4'd1, 16'd3,    1, 4'd1, 3'b010, 1, 16'd3,     0);
        step("mx_exec2",     0, 0, 3'b010, 4'd2, 16'd5,    1, 4'd2, 3'b010, 1, 16'd5,     0);
        step("mx_drain",     0, 0, 3'b100, 4'd0, 16'd0,    1, 4'd2, 3'b100, 1, 16'd13,    1);
        step("mx_pass",      0, 0, 3'b100, 4'd0, 16'h0042, 1, 4'd2, 3'b100, 1, 16'h0042,  1);

        // Reset while in DRAIN_PASS
        step("rst_drain",    1, 0, 3'b100, 4'd9, 16'h0055, 1, 4'd0, 3'b000, 1, 16'd0,     0);
        step("rst_after",    0, 0, 3'b000, 4'd9, 16'h0055, 1, 4'd0, 3'b000, 1, 16'd0,     0);

        // After reset: WS mode and load_ready re-armed; negative weight -6
        step("rearm_load",   0, 0, 3'b001, 4'hA, 16'd0,    1, 4'hA, 3'b000, 1, 16'd0,     0);
        step("rearm_exec",   0, 0, 3'b010, 4'd2, 16'd1,    1, 4'd2, 3'b010, 1, 16'hFFF5,  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mac_tile_flex
